multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle RV32I core. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives the immediate-generator format select, ALU operand muxes, PC/IR/register-file write enables and the instruction/data memory request handshakes. Traps on illegal opcodes and on memory timeouts.

Parameters:
MEM_TIMEOUT, 15, maximum wait cycles for imem_ack/dmem_ack before trapping (range 1..255)
CNT_W, 32, width of the optional performance counters

Ports:
clk  in  1  core clock, rising edge
rst  in  1  reset, synchronous, active-high
opcode  in  7  instr[6:0] from IR, valid from DECODE onward
branch_taken  in  1  ALU compare result, valid in EXEC
imem_req  out  1  instruction fetch request
imem_ack  in  1  fetch data valid, IR loads on this cycle
dmem_req  out  1  data memory request
dmem_we  out  1  1 = store, 0 = load
dmem_ack  in  1  data access complete
ir_we  out  1  IR load enable
pc_we  out  1  PC update enable
pc_src  out  2  0 = pc+4, 1 = pc+imm (branch/JAL), 2 = ALU result (JALR)
reg_we  out  1  register file write enable
wb_sel  out  2  0 = ALU, 1 = load data, 2 = pc+4
imm_sel  out  3  0 = I, 1 = S, 2 = B, 3 = J, 4 = U
alu_src_a  out  1  0 = rs1, 1 = PC (AUIPC)
alu_src_b  out  1  0 = rs2, 1 = immediate
fault  out  1  sticky trap indicator
fault_cause  out  2  0 = none, 1 = illegal opcode, 2 = imem timeout, 3 = dmem timeout
state  out  3  current state, for debug

Behaviour:
- Opcodes: R 0110011, OPIMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111. Any other opcode is illegal.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Encodings 6 and 7 go to TRAP with cause 1.
- Reset: on a clk edge with rst=1, state becomes FETCH, and wait_cnt, fault, fault_cause, the latched opcode and the counters clear. While rst=1, every req, we and enable output is forced to 0. rst mid-operation abandons the outstanding request with no further write enables.
- FETCH: imem_req=1 until imem_ack. On the ack cycle ir_we=1 and the next state is DECODE.
- DECODE: one cycle. Opcode is latched internally. Illegal opcode goes to TRAP (cause 1); otherwise EXEC.
- imm_sel is decoded from the latched opcode and is held from DECODE through WB:
  - I for OPIMM, LOAD, JALR
  - S for STORE
  - B for BRANCH
  - J for JAL
  - U for LUI, AUIPC
  - 0 in FETCH and TRAP
- EXEC:
  - alu_src_b=1 for all except R and BRANCH.
  - alu_src_a=1 only for AUIPC.
  - BRANCH: pc_we=1, pc_src=1 if branch_taken else 0, then FETCH.
  - LOAD/STORE go to MEM; all others go to WB.
- MEM: dmem_req=1 and dmem_we=(STORE), both held until dmem_ack. On ack, STORE asserts pc_we=1, pc_src=0 and goes to FETCH; LOAD goes to WB.
- WB: one cycle, reg_we=1, pc_we=1.
  - pc_src: 1 for JAL, 2 for JALR, otherwise 0.
  - wb_sel: 2 for JAL/JALR, 1 for LOAD, otherwise 0.
  - Next state is FETCH.
- Timeout:
  - wait_cnt clears on entry to FETCH or MEM and increments on each cycle with req=1 and ack=0.
  - If ack=0 while wait_cnt==MEM_TIMEOUT-1, go to TRAP (cause 2 or 3).
  - Ack arriving on that same cycle wins; no trap.
- TRAP: absorbing until rst. All req, we and enables are 0; fault=1; fault_cause holds the first cause.
- Ack received outside its matching request state is ignored.
- Latency with zero-wait memory: 4 cycles for R/I/U/JAL/JALR, 3 for branches, 4 for stores, 5 for loads.
- Outputs are decoded from state and latched opcode only (Moore), with ack-qualified enables as above.

Optional Feature:
PERF_CNT_EN. When defined, adds outputs cycle_cnt[CNT_W-1:0] and instret_cnt[CNT_W-1:0].
- cycle_cnt increments every non-reset cycle, except in TRAP.
- instret_cnt increments on every cycle with pc_we=1.
- Both wrap modulo 2^CNT_W and clear on rst.

When not defined, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
1. addi (0x00500093) with immediate ack → states 0,1,2,4,0. ir_we in cycle 0, imm_sel=0 in cycles 1–3, reg_we=pc_we=1, pc_src=0 in cycle 3.
2. lw with dmem_ack 3 cycles after entering MEM → dmem_req high for 3 cycles, dmem_we=0, then WB with wb_sel=1. Total 7 cycles.
3. beq with branch_taken=1, then again with 0 → EXEC pc_we=1, pc_src=1 then 0, imm_sel=2, back to FETCH after 3 cycles.
4. Opcode 0x7F → TRAP after DECODE, fault=1, fault_cause=1. No further imem_req until rst.
5. MEM_TIMEOUT=4 with imem_ack held 0 → imem_req high for 4 cycles, then TRAP, fault_cause=2. Repeat with ack in the 4th cycle → DECODE, no fault.
6. rst asserted in MEM during a store wait → next cycle state=FETCH, dmem_req=0, no pc_we. With PERF_CNT_EN defined, both counters read 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core: sequences fetch/decode/exec/mem/writeback and traps on
// illegal opcodes or memory timeouts. Define PERF_CNT_EN to add the cycle_cnt/instret_cnt performance counters.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic [2:0]       imm_sel,
  output logic             alu_src_a,
  output logic             alu_src_b,
  output logic             fault,
  output logic [1:0]       fault_cause,
  output logic [2:0]       state
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt, wait_d;
  logic       fault_q;
  logic [1:0] cause_q, trap_cause;
  logic [6:0] op_q;

  function automatic logic is_legal(input logic [6:0] op);
    return op inside {OP_R, OP_OPIMM, OP_LOAD, OP_STORE, OP_BRANCH,
                      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
  endfunction

  function automatic logic [2:0] imm_dec(input logic [6:0] op);
    case (op)
      OP_STORE:         return 3'd1;
      OP_BRANCH:        return 3'd2;
      OP_JAL:           return 3'd3;
      OP_LUI, OP_AUIPC: return 3'd4;
      default:          return 3'd0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      wait_cnt <= '0;
      fault_q  <= 1'b0;
      cause_q  <= 2'd0;
      op_q     <= '0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= wait_d;
      if (state_q == S_DECODE) op_q <= opcode;
      // First trap cause is captured and then held until reset.
      if (state_d == S_TRAP && !fault_q) begin
        fault_q <= 1'b1;
        cause_q <= trap_cause;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_cnt;
    trap_cause = 2'd0;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'd0;
    reg_we     = 1'b0;
    wb_sel     = 2'd0;
    imm_sel    = 3'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_d    = S_TRAP;
          trap_cause = 2'd2;
        end else begin
          wait_d = wait_cnt + 8'd1;
        end
      end
      S_DECODE: begin
        // op_q is only loaded at the end of this cycle, so decode the IR field directly.
        imm_sel = imm_dec(opcode);
        if (!is_legal(opcode)) begin
          state_d    = S_TRAP;
          trap_cause = 2'd1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        imm_sel   = imm_dec(op_q);
        alu_src_a = (op_q == OP_AUIPC);
        alu_src_b = !(op_q == OP_R || op_q == OP_BRANCH);
        if (op_q == OP_BRANCH) begin
          pc_we   = 1'b1;
          pc_src  = branch_taken ? 2'd1 : 2'd0;
          state_d = S_FETCH;
          wait_d  = '0;
        end else if (op_q == OP_LOAD || op_q == OP_STORE) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        imm_sel  = imm_dec(op_q);
        dmem_req = 1'b1;
        dmem_we  = (op_q == OP_STORE);
        if (dmem_ack) begin
          if (op_q == OP_STORE) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
            wait_d  = '0;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          state_d    = S_TRAP;
          trap_cause = 2'd3;
        end else begin
          wait_d = wait_cnt + 8'd1;
        end
      end
      S_WB: begin
        imm_sel = imm_dec(op_q);
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        pc_src  = (op_q == OP_JAL) ? 2'd1 : (op_q == OP_JALR) ? 2'd2 : 2'd0;
        wb_sel  = (op_q == OP_JAL || op_q == OP_JALR) ? 2'd2 :
                  (op_q == OP_LOAD) ? 2'd1 : 2'd0;
        state_d = S_FETCH;
        wait_d  = '0;
      end
      S_TRAP: state_d = S_TRAP;
      default: begin
        state_d    = S_TRAP;
        trap_cause = 2'd1;
      end
    endcase

    // Reset kills any outstanding request and every write enable immediately.
    if (rst) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      reg_we   = 1'b0;
    end
  end

  assign state       = state_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;

`ifdef PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state_q != S_TRAP) cycle_cnt <= cycle_cnt + 1'b1;
      if (pc_we) instret_cnt <= instret_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected output sequences from a
// behavioural model, directed scenarios plus randomized instruction streams with random memory waits.
module tb_multicycle_ctrl;
  localparam int T = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = '0;
  logic       branch_taken = 1'b0;
  logic       imem_ack = 1'b0;
  logic       dmem_ack = 1'b0;
  logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we;
  logic       alu_src_a, alu_src_b, fault;
  logic [1:0] pc_src, wb_sel, fault_cause;
  logic [2:0] imm_sel, state;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(T), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
    .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
    .wb_sel(wb_sel), .imm_sel(imm_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .fault(fault), .fault_cause(fault_cause), .state(state)
`ifdef PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  typedef struct packed {
    logic [2:0] state;
    logic       imem_req, ir_we, dmem_req, dmem_we, pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic [2:0] imm_sel;
    logic       alu_src_a, alu_src_b, fault;
    logic [1:0] fault_cause;
  } obs_t;

  typedef struct packed {
    obs_t       o;
    logic       iack, dack, bt;
    logic [6:0] op;
  } cyc_t;

  cyc_t exp_q[$];
  obs_t got;
  int   vecs = 0;
  int   errs = 0;

  function automatic obs_t mk(input logic [2:0] s);
    obs_t o = '0;
    o.state = s;
    return o;
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    if (op == OP_OPIMM || op == OP_LOAD || op == OP_JALR) return 3'd0;
    if (op == OP_STORE)  return 3'd1;
    if (op == OP_BRANCH) return 3'd2;
    if (op == OP_JAL)    return 3'd3;
    if (op == OP_LUI || op == OP_AUIPC) return 3'd4;
    return 3'd0;
  endfunction

  function automatic bit legal(input logic [6:0] op);
    return op inside {OP_R, OP_OPIMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
  endfunction

  task automatic push(input obs_t o, input logic iack, input logic dack, input logic bt,
                      input logic [6:0] op);
    cyc_t c;
    c.o = o; c.iack = iack; c.dack = dack; c.bt = bt; c.op = op;
    exp_q.push_back(c);
  endtask

  task automatic push_trap(input logic [1:0] cause, input logic [6:0] op);
    for (int k = 0; k < 3; k++) begin
      obs_t o = mk(3'd5);
      o.fault = 1'b1;
      o.fault_cause = cause;
      push(o, 1'($urandom), 1'($urandom), 1'($urandom), op);
    end
  endtask

  // Expected cycle-by-cycle behaviour of one instruction; iw/dw = idle cycles before the ack.
  task automatic build(input logic [6:0] op, input logic bt, input int iw, input int dw);
    obs_t o;
    int   n;
    n = (iw >= T) ? T : iw;
    for (int k = 0; k < n; k++) begin
      o = mk(3'd0); o.imem_req = 1'b1;
      push(o, 1'b0, 1'($urandom), 1'($urandom), 7'($urandom));
    end
    if (iw >= T) begin push_trap(2'd2, op); return; end
    o = mk(3'd0); o.imem_req = 1'b1; o.ir_we = 1'b1;
    push(o, 1'b1, 1'($urandom), 1'($urandom), 7'($urandom));
    o = mk(3'd1); o.imm_sel = imm_of(op);
    push(o, 1'($urandom), 1'($urandom), 1'($urandom), op);
    if (!legal(op)) begin push_trap(2'd1, op); return; end
    o = mk(3'd2); o.imm_sel = imm_of(op);
    o.alu_src_a = (op == OP_AUIPC);
    o.alu_src_b = !(op == OP_R || op == OP_BRANCH);
    if (op == OP_BRANCH) begin
      o.pc_we = 1'b1; o.pc_src = bt ? 2'd1 : 2'd0;
      push(o, 1'($urandom), 1'($urandom), bt, op);
      return;
    end
    push(o, 1'($urandom), 1'($urandom), 1'($urandom), op);
    if (op == OP_LOAD || op == OP_STORE) begin
      n = (dw >= T) ? T : dw;
      for (int k = 0; k < n; k++) begin
        o = mk(3'd3); o.imm_sel = imm_of(op); o.dmem_req = 1'b1; o.dmem_we = (op == OP_STORE);
        push(o, 1'($urandom), 1'b0, 1'($urandom), op);
      end
      if (dw >= T) begin push_trap(2'd3, op); return; end
      o = mk(3'd3); o.imm_sel = imm_of(op); o.dmem_req = 1'b1; o.dmem_we = (op == OP_STORE);
      if (op == OP_STORE) begin
        o.pc_we = 1'b1;
        push(o, 1'($urandom), 1'b1, 1'($urandom), op);
        return;
      end
      push(o, 1'($urandom), 1'b1, 1'($urandom), op);
    end
    o = mk(3'd4); o.imm_sel = imm_of(op); o.reg_we = 1'b1; o.pc_we = 1'b1;
    o.pc_src = (op == OP_JAL) ? 2'd1 : (op == OP_JALR) ? 2'd2 : 2'd0;
    o.wb_sel = (op == OP_JAL || op == OP_JALR) ? 2'd2 : (op == OP_LOAD) ? 2'd1 : 2'd0;
    push(o, 1'($urandom), 1'($urandom), 1'($urandom), op);
  endtask

  // Called just after a falling edge: drive, sample, advance to the next falling edge.
  task automatic apply(input cyc_t c, output obs_t a);
    imem_ack = c.iack; dmem_ack = c.dack; branch_taken = c.bt; opcode = c.op;
    #1;
    a.state = state; a.imem_req = imem_req; a.ir_we = ir_we; a.dmem_req = dmem_req;
    a.dmem_we = dmem_we; a.pc_we = pc_we; a.pc_src = pc_src; a.reg_we = reg_we;
    a.wb_sel = wb_sel; a.imm_sel = imm_sel; a.alu_src_a = alu_src_a; a.alu_src_b = alu_src_b;
    a.fault = fault; a.fault_cause = fault_cause;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1; opcode = OP_STORE;
    #1;
    vecs++;
    if ({imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we} !== 6'b0) begin
      errs++;
      $display("FAIL reset_gate got=%b want=000000", {imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we});
    end
    @(negedge clk);
    #1;
    vecs++;
    if ({state, fault, fault_cause, imem_req, ir_we} !== 8'b0) begin
      errs++;
      $display("FAIL reset_state got=%b want=00000000", {state, fault, fault_cause, imem_req, ir_we});
    end
    rst = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    #1;
    vecs++;
    if ({state, imem_req, ir_we} !== 5'b00010) begin
      errs++;
      $display("FAIL reset_release got=%b want=00010", {state, imem_req, ir_we});
    end
`ifdef PERF_CNT_EN
    vecs++;
    if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
      errs++;
      $display("FAIL reset_cnt got=%0d/%0d want=0/0", cycle_cnt, instret_cnt);
    end
`endif
    @(negedge clk);
    do_reset();
  endtask

  task automatic test_fixed();
    do_reset();
    exp_q.delete();
    build(7'h13, 1'b0, 0, 0);
    foreach (exp_q[i]) begin
      apply(exp_q[i], got);
      vecs++;
      if (got !== exp_q[i].o) begin
        errs++;
        $display("FAIL addi[%0d] got=%h want=%h", i, got, exp_q[i].o);
      end
    end
`ifdef PERF_CNT_EN
    vecs++;
    if (cycle_cnt !== 32'd4 || instret_cnt !== 32'd1) begin
      errs++;
      $display("FAIL addi_cnt got=%0d/%0d want=4/1", cycle_cnt, instret_cnt);
    end
`endif
    exp_q.delete();
    build(OP_LOAD, 1'b0, 0, 2);
    build(OP_BRANCH, 1'b1, 0, 0);
    build(OP_BRANCH, 1'b0, 0, 0);
    build(OP_STORE, 1'b0, 1, 0);
    build(OP_JALR, 1'b0, 0, 0);
    foreach (exp_q[i]) begin
      apply(exp_q[i], got);
      vecs++;
      if (got !== exp_q[i].o) begin
        errs++;
        $display("FAIL fixed[%0d] got=%h want=%h", i, got, exp_q[i].o);
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    exp_q.delete();
    build(7'h7F, 1'b0, 0, 0);
    foreach (exp_q[i]) begin
      apply(exp_q[i], got);
      vecs++;
      if (got !== exp_q[i].o) begin
        errs++;
        $display("FAIL illegal[%0d] got=%h want=%h", i, got, exp_q[i].o);
      end
    end
  endtask

  task automatic test_timeout();
    exp_q.delete();
    do_reset();
    build(OP_OPIMM, 1'b0, T, 0);
    foreach (exp_q[i]) begin
      apply(exp_q[i], got);
      vecs++;
      if (got !== exp_q[i].o) begin
        errs++;
        $display("FAIL imem_to[%0d] got=%h want=%h", i, got, exp_q[i].o);
      end
    end
    exp_q.delete();
    do_reset();
    build(OP_OPIMM, 1'b0, T - 1, 0);
    build(OP_LOAD, 1'b0, 0, T - 1);
    build(OP_STORE, 1'b0, 0, T);
    foreach (exp_q[i]) begin
      apply(exp_q[i], got);
      vecs++;
      if (got !== exp_q[i].o) begin
        errs++;
        $display("FAIL mem_to[%0d] got=%h want=%h", i, got, exp_q[i].o);
      end
    end
  endtask

  task automatic test_rst_mid_store();
    do_reset();
    exp_q.delete();
    build(OP_STORE, 1'b0, 0, 10);
    for (int i = 0; i < 5; i++) begin
      apply(exp_q[i], got);
      vecs++;
      if (got !== exp_q[i].o) begin
        errs++;
        $display("FAIL store_pre[%0d] got=%h want=%h", i, got, exp_q[i].o);
      end
    end
    rst = 1'b1; dmem_ack = 1'b1; imem_ack = 1'b0;
    #1;
    vecs++;
    if ({state, dmem_req, dmem_we, pc_we} !== 6'b011000) begin
      errs++;
      $display("FAIL rst_in_mem got=%b want=011000", {state, dmem_req, dmem_we, pc_we});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vecs++;
    if ({state, dmem_req, pc_we, imem_req, fault} !== 7'b0000010) begin
      errs++;
      $display("FAIL rst_after_mem got=%b want=0000010", {state, dmem_req, pc_we, imem_req, fault});
    end
`ifdef PERF_CNT_EN
    vecs++;
    if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
      errs++;
      $display("FAIL rst_cnt got=%0d/%0d want=0/0", cycle_cnt, instret_cnt);
    end
`endif
    dmem_ack = 1'b0;
    @(negedge clk);
    do_reset();
  endtask

  task automatic test_random();
    logic [6:0] ops [9];
    logic [6:0] op;
    ops[0] = OP_R; ops[1] = OP_OPIMM; ops[2] = OP_LOAD; ops[3] = OP_STORE; ops[4] = OP_BRANCH;
    ops[5] = OP_JAL; ops[6] = OP_JALR; ops[7] = OP_LUI; ops[8] = OP_AUIPC;
    do_reset();
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        op = 7'($urandom);
        while (legal(op)) op = 7'($urandom);
      end else begin
        op = ops[$urandom_range(0, 8)];
      end
      exp_q.delete();
      build(op, 1'($urandom),
            ($urandom_range(0, 5) == 0) ? T : int'($urandom_range(0, T - 1)),
            ($urandom_range(0, 5) == 0) ? T : int'($urandom_range(0, T - 1)));
      foreach (exp_q[i]) begin
        apply(exp_q[i], got);
        vecs++;
        if (got !== exp_q[i].o) begin
          errs++;
          $display("FAIL rand%0d op=%h [%0d] got=%h want=%h", n, op, i, got, exp_q[i].o);
        end
      end
      if (exp_q[exp_q.size() - 1].o.state == 3'd5) do_reset();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_fixed();
    test_illegal();
    test_timeout();
    test_rst_mid_store();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
